// File: rtl/alu_pkg.sv
// Shared constants, instruction field layout and decode helpers for the ALU
// issue/writeback front end.
package alu_pkg;

   localparam int DW   = 16;
   localparam int NREG = 16;
   localparam int AW   = $clog2(NREG);
   localparam int OPW  = 8;

   localparam logic [OPW-1:0] OP_NOP = 8'd0;
   localparam logic [OPW-1:0] OP_ADD = 8'd1;
   localparam logic [OPW-1:0] OP_SUB = 8'd2;
   localparam logic [OPW-1:0] OP_AND = 8'd3;
   localparam logic [OPW-1:0] OP_OR  = 8'd4;

   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 24;
   localparam int RD_MSB  = 23;
   localparam int RD_LSB  = 20;
   localparam int RS1_MSB = 19;
   localparam int RS1_LSB = 16;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;
   localparam int RS2_MSB = 3;
   localparam int RS2_LSB = 0;

   typedef struct packed {
      logic [OPW-1:0] op;
      logic [AW-1:0]  rd;
      logic [AW-1:0]  rs1;
      logic [AW-1:0]  rs2;
      logic [DW-1:0]  imm;
   } instr_t;

   // rs2 overlaps the low nibble of the immediate.
   function automatic instr_t decode(input logic [31:0] raw);
      instr_t d;
      d.op  = raw[OP_MSB:OP_LSB];
      d.rd  = raw[RD_MSB:RD_LSB];
      d.rs1 = raw[RS1_MSB:RS1_LSB];
      d.rs2 = raw[RS2_MSB:RS2_LSB];
      d.imm = raw[IMM_MSB:IMM_LSB];
      return d;
   endfunction

   function automatic logic op_legal(input logic [OPW-1:0] op);
      return (op == OP_NOP) || (op == OP_ADD) || (op == OP_SUB) ||
             (op == OP_AND) || (op == OP_OR);
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREG x DW register file: two asynchronous read ports, one synchronous write
// port, r0 hard-wired to zero, cleared by synchronous reset.
module alu_regfile
   import alu_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] ra_addr,
   output logic [DW-1:0] ra_data,
   input  logic [AW-1:0] rb_addr,
   output logic [DW-1:0] rb_data,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd
);

   logic [DW-1:0] mem_q [NREG];
   logic [DW-1:0] mem_d [NREG];

   // NOTE: every always_comb output gets a full default first so no latch is inferred.
   always_comb begin
      mem_d = mem_q;
      if (we && (wa != '0)) begin
         mem_d[wa] = wd;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   // NOTE: the array is cleared on reset because architectural state must read 0 afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign ra_data = (ra_addr == '0) ? '0 : mem_q[ra_addr];
   assign rb_data = (rb_addr == '0) ? '0 : mem_q[rb_addr];

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback front end for the registered ALU: decode, RF read with
// W-stage forwarding, single-cycle load-use interlock, E/W pipeline registers.
module alu_issue
   import alu_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [31:0]    in_instr,
   output logic [OPW-1:0] alu_op,
   output logic [DW-1:0]  alu_a,
   output logic [DW-1:0]  alu_b,
   output logic [DW-1:0]  alu_imm,
   input  logic [DW-1:0]  alu_c,
   output logic           wb_valid,
   output logic [AW-1:0]  wb_rd,
   output logic [DW-1:0]  wb_data,
   output logic           illegal
);

   instr_t         dec;
   logic [DW-1:0]  rf_a, rf_b;
   logic           hazard, accept, fwd_ok;
   logic [DW-1:0]  opnd_a, opnd_b;

   logic           valid_e_q, valid_e_d;
   logic [OPW-1:0] op_e_q,    op_e_d;
   logic [DW-1:0]  a_e_q,     a_e_d;
   logic [DW-1:0]  b_e_q,     b_e_d;
   logic [DW-1:0]  imm_e_q,   imm_e_d;
   logic [AW-1:0]  rd_e_q,    rd_e_d;
   logic           valid_w_q, valid_w_d;
   logic [AW-1:0]  rd_w_q,    rd_w_d;
   logic           illegal_q, illegal_d;

   alu_regfile u_rf (
      .clk     (clk),
      .rst     (rst),
      .ra_addr (dec.rs1),
      .ra_data (rf_a),
      .rb_addr (dec.rs2),
      .rb_data (rf_b),
      .we      (wb_valid),
      .wa      (rd_w_q),
      .wd      (alu_c)
   );

   always_comb begin
      dec    = decode(in_instr);
      // The E-stage result is not visible until W, so a match costs one bubble.
      hazard = valid_e_q && (rd_e_q != '0) &&
               ((dec.rs1 == rd_e_q) || (dec.rs2 == rd_e_q));
      in_ready = !rst && !hazard;
      accept   = in_valid && in_ready;

      // Forwarding from W also covers the same-cycle RF write (write-first).
      fwd_ok = valid_w_q && (rd_w_q != '0);
      opnd_a = (fwd_ok && (dec.rs1 == rd_w_q)) ? alu_c : rf_a;
      opnd_b = (fwd_ok && (dec.rs2 == rd_w_q)) ? alu_c : rf_b;

      // NOP and illegal opcodes occupy the slot but never reach the ALU or RF.
      valid_e_d = accept && op_legal(dec.op) && (dec.op != OP_NOP);
      op_e_d    = op_e_q;
      a_e_d     = a_e_q;
      b_e_d     = b_e_q;
      imm_e_d   = imm_e_q;
      rd_e_d    = rd_e_q;
      if (valid_e_d) begin
         op_e_d  = dec.op;
         a_e_d   = opnd_a;
         b_e_d   = opnd_b;
         imm_e_d = dec.imm;
         rd_e_d  = dec.rd;
      end

      valid_w_d = valid_e_q;
      rd_w_d    = rd_e_q;
      illegal_d = accept && !op_legal(dec.op);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_e_q <= 1'b0;
         op_e_q    <= OP_NOP;
         a_e_q     <= '0;
         b_e_q     <= '0;
         imm_e_q   <= '0;
         rd_e_q    <= '0;
         valid_w_q <= 1'b0;
         rd_w_q    <= '0;
         illegal_q <= 1'b0;
      end else begin
         valid_e_q <= valid_e_d;
         op_e_q    <= op_e_d;
         a_e_q     <= a_e_d;
         b_e_q     <= b_e_d;
         imm_e_q   <= imm_e_d;
         rd_e_q    <= rd_e_d;
         valid_w_q <= valid_w_d;
         rd_w_q    <= rd_w_d;
         illegal_q <= illegal_d;
      end
   end

   assign alu_op   = valid_e_q ? op_e_q : OP_NOP;
   assign alu_a    = a_e_q;
   assign alu_b    = b_e_q;
   assign alu_imm  = imm_e_q;
   assign wb_valid = valid_w_q && (rd_w_q != '0);
   assign wb_rd    = rd_w_q;
   assign wb_data  = alu_c;
   assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a small registered ALU model; the model's
// OR also folds in the immediate so constants can be loaded into registers.
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [7:0]  alu_op;
   logic [15:0] alu_a, alu_b, alu_imm;
   logic [15:0] alu_c;
   logic        wb_valid;
   logic [3:0]  wb_rd;
   logic [15:0] wb_data;
   logic        illegal;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ill_cnt = 0;

   typedef struct packed {
      logic [3:0]  rd;
      logic [15:0] data;
      logic [31:0] cyc;
   } wb_t;
   wb_t wb_log[$];

   always #5 clk = ~clk;

   alu_issue dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_instr (in_instr),
      .alu_op   (alu_op),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_imm  (alu_imm),
      .alu_c    (alu_c),
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .illegal  (illegal)
   );

   // Registered ALU: result valid one cycle after operands, held on NOP.
   always @(posedge clk) begin
      if (rst) alu_c <= 16'h0000;
      else begin
         case (alu_op)
            8'd1: alu_c <= alu_a + alu_b;
            8'd2: alu_c <= alu_a - alu_b;
            8'd3: alu_c <= alu_a & alu_b;
            8'd4: alu_c <= alu_a | alu_b | alu_imm;
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (wb_valid) wb_log.push_back('{rd: wb_rd, data: wb_data, cyc: cyc});
      if (illegal) ill_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mk(input logic [7:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [15:0] imm);
      return {op, rd, rs1, imm};
   endfunction

   // Returns 1 ns after the accepting edge, with the instruction now in E.
   task automatic issue(input logic [31:0] instr, output int stalls);
      in_valid = 1'b1;
      in_instr = instr;
      stalls   = 0;
      #1;
      while (!in_ready && stalls < 8) begin
         stalls++;
         @(posedge clk); #1;
      end
      checks++;
      if (stalls >= 8) begin
         errors++;
         $display("FAIL issue_timeout: instr %h not accepted after %0d cycles", instr, stalls);
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; in_instr = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      checks++; if (alu_op !== 8'h00) begin errors++; $display("FAIL rst_alu_op: got %h want 00", alu_op); end
      checks++; if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_imm !== 16'h0) begin
         errors++; $display("FAIL rst_operands: got %h %h %h want 0 0 0", alu_a, alu_b, alu_imm); end
      checks++; if (wb_valid !== 1'b0 || illegal !== 1'b0 || wb_rd !== 4'h0) begin
         errors++; $display("FAIL rst_outputs: wb_valid %b illegal %b wb_rd %h want 0 0 0", wb_valid, illegal, wb_rd); end
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_first_add;
      int st;
      wb_log.delete();
      issue(mk(8'd1, 4'd1, 4'd0, 16'h0005), st);
      checks++; if (alu_op !== 8'd1 || alu_a !== 16'h0 || alu_b !== 16'h0 || alu_imm !== 16'h0005) begin
         errors++; $display("FAIL add_operands: got op %h a %h b %h imm %h want 01 0000 0000 0005", alu_op, alu_a, alu_b, alu_imm); end
      idle(4);
      checks++; if (wb_log.size() != 1) begin errors++; $display("FAIL add_wb_count: got %0d want 1", wb_log.size()); end
      else begin
         checks++; if (wb_log[0].rd !== 4'd1 || wb_log[0].data !== 16'h0000) begin
            errors++; $display("FAIL add_wb: got r%0d=%h want r1=0000", wb_log[0].rd, wb_log[0].data); end
      end
   endtask

   task automatic test_back_to_back;
      int st_a, st_b;
      issue(mk(8'd4, 4'd1, 4'd0, 16'h00F0), st_a);
      issue(mk(8'd4, 4'd2, 4'd0, 16'h0F0F), st_b);
      idle(4);
      wb_log.delete();
      issue(mk(8'd4, 4'd3, 4'd1, 16'h0002), st_a);
      checks++; if (alu_a !== 16'h00F0 || alu_b !== 16'h0F0F) begin
         errors++; $display("FAIL or_operands: got a %h b %h want 00f0 0f0f", alu_a, alu_b); end
      issue(mk(8'd3, 4'd4, 4'd1, 16'h0002), st_b);
      idle(4);
      checks++; if (st_a + st_b != 0) begin errors++; $display("FAIL b2b_stalls: got %0d want 0", st_a + st_b); end
      checks++; if (wb_log.size() != 2) begin errors++; $display("FAIL b2b_wb_count: got %0d want 2", wb_log.size()); end
      else begin
         checks++; if (wb_log[0].rd !== 4'd3 || wb_log[0].data !== 16'h0FFF) begin
            errors++; $display("FAIL or_wb: got r%0d=%h want r3=0fff", wb_log[0].rd, wb_log[0].data); end
         checks++; if (wb_log[1].rd !== 4'd4 || wb_log[1].data !== 16'h0000) begin
            errors++; $display("FAIL and_wb: got r%0d=%h want r4=0000", wb_log[1].rd, wb_log[1].data); end
         checks++; if (wb_log[1].cyc != wb_log[0].cyc + 1) begin
            errors++; $display("FAIL b2b_consecutive: got cycles %0d,%0d want adjacent", wb_log[0].cyc, wb_log[1].cyc); end
      end
   endtask

   task automatic test_interlock;
      int st;
      wb_log.delete();
      issue(mk(8'd2, 4'd5, 4'd2, 16'h0001), st);
      checks++; if (alu_a !== 16'h0F0F || alu_b !== 16'h00F0) begin
         errors++; $display("FAIL sub_operands: got a %h b %h want 0f0f 00f0", alu_a, alu_b); end
      issue(mk(8'd1, 4'd6, 4'd5, 16'h0001), st);
      checks++; if (st != 1) begin errors++; $display("FAIL interlock_stalls: got %0d want 1", st); end
      checks++; if (alu_a !== 16'h0E1F || alu_b !== 16'h00F0) begin
         errors++; $display("FAIL forward_operand: got a %h b %h want 0e1f 00f0", alu_a, alu_b); end
      idle(4);
      checks++; if (wb_log.size() != 2) begin errors++; $display("FAIL interlock_wb_count: got %0d want 2", wb_log.size()); end
      else begin
         checks++; if (wb_log[0].rd !== 4'd5 || wb_log[0].data !== 16'h0E1F) begin
            errors++; $display("FAIL sub_wb: got r%0d=%h want r5=0e1f", wb_log[0].rd, wb_log[0].data); end
         checks++; if (wb_log[1].rd !== 4'd6 || wb_log[1].data !== 16'h0F0F) begin
            errors++; $display("FAIL fwd_add_wb: got r%0d=%h want r6=0f0f", wb_log[1].rd, wb_log[1].data); end
      end
   endtask

   task automatic test_illegal;
      int st_a, st_b;
      wb_log.delete();
      ill_cnt = 0;
      issue(mk(8'h09, 4'd7, 4'd1, 16'h0002), st_a);
      checks++; if (illegal !== 1'b1 || alu_op !== 8'h00) begin
         errors++; $display("FAIL illegal_pulse: got illegal %b op %h want 1 00", illegal, alu_op); end
      issue(mk(8'd1, 4'd8, 4'd1, 16'h0002), st_b);
      checks++; if (illegal !== 1'b0 || alu_op !== 8'd1 || alu_a !== 16'h00F0) begin
         errors++; $display("FAIL after_illegal: got illegal %b op %h a %h want 0 01 00f0", illegal, alu_op, alu_a); end
      idle(4);
      checks++; if (st_a + st_b != 0) begin errors++; $display("FAIL illegal_stalls: got %0d want 0", st_a + st_b); end
      checks++; if (ill_cnt != 1) begin errors++; $display("FAIL illegal_width: got %0d cycles want 1", ill_cnt); end
      checks++; if (wb_log.size() != 1) begin errors++; $display("FAIL illegal_wb_count: got %0d want 1", wb_log.size()); end
      else begin
         checks++; if (wb_log[0].rd !== 4'd8 || wb_log[0].data !== 16'h0FFF) begin
            errors++; $display("FAIL post_illegal_wb: got r%0d=%h want r8=0fff", wb_log[0].rd, wb_log[0].data); end
      end
   endtask

   task automatic test_r0_write;
      int st_a, st_b, st_c;
      wb_log.delete();
      issue(mk(8'd1, 4'd0, 4'd1, 16'h0002), st_a);
      issue(mk(8'd2, 4'd9, 4'd0, 16'h0000), st_b);
      issue(mk(8'd4, 4'd7, 4'd0, 16'h0000), st_c);
      checks++; if (alu_a !== 16'h0000 || alu_b !== 16'h0000) begin
         errors++; $display("FAIL r0_read: got a %h b %h want 0000 0000", alu_a, alu_b); end
      idle(4);
      checks++; if (st_a + st_b + st_c != 0) begin errors++; $display("FAIL r0_stalls: got %0d want 0", st_a + st_b + st_c); end
      checks++; if (wb_log.size() != 2) begin errors++; $display("FAIL r0_wb_count: got %0d want 2", wb_log.size()); end
      else begin
         checks++; if (wb_log[0].rd !== 4'd9 || wb_log[0].data !== 16'h0000 ||
                       wb_log[1].rd !== 4'd7 || wb_log[1].data !== 16'h0000) begin
            errors++; $display("FAIL r0_wb: got r%0d=%h r%0d=%h want r9=0000 r7=0000",
                               wb_log[0].rd, wb_log[0].data, wb_log[1].rd, wb_log[1].data); end
      end
   endtask

   task automatic test_reset_midstream;
      int st;
      issue(mk(8'd1, 4'd10, 4'd1, 16'h0002), st);
      issue(mk(8'd4, 4'd11, 4'd1, 16'h0002), st);
      rst = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b0 || wb_valid !== 1'b0 || alu_op !== 8'h00) begin
         errors++; $display("FAIL midrst_state: got ready %b wb_valid %b op %h want 0 0 00", in_ready, wb_valid, alu_op); end
      rst = 1'b0;
      wb_log.delete();
      idle(4);
      checks++; if (wb_log.size() != 0) begin errors++; $display("FAIL midrst_no_wb: got %0d writebacks want 0", wb_log.size()); end
      issue(mk(8'd4, 4'd12, 4'd1, 16'h0002), st);
      checks++; if (alu_a !== 16'h0000 || alu_b !== 16'h0000) begin
         errors++; $display("FAIL midrst_regs: got a %h b %h want 0000 0000", alu_a, alu_b); end
      issue(mk(8'd2, 4'd13, 4'd5, 16'h0006), st);
      checks++; if (alu_a !== 16'h0000 || alu_b !== 16'h0000) begin
         errors++; $display("FAIL midrst_regs2: got a %h b %h want 0000 0000", alu_a, alu_b); end
      idle(4);
      checks++; if (wb_log.size() != 2) begin errors++; $display("FAIL midrst_wb_count: got %0d want 2", wb_log.size()); end
      else begin
         checks++; if (wb_log[0].rd !== 4'd12 || wb_log[0].data !== 16'h0002) begin
            errors++; $display("FAIL midrst_wb: got r%0d=%h want r12=0002", wb_log[0].rd, wb_log[0].data); end
      end
   endtask

   initial begin
      test_reset();
      test_first_add();
      test_back_to_back();
      test_interlock();
      test_illegal();
      test_r0_write();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
